// File: rtl/udiv_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package udiv_pkg;

    localparam int unsigned UDIV_WIDTH = 64;
    localparam int unsigned UDIV_MAX_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE
    } udiv_state_e;

    // Two's-complement magnitude; callers zero-extend in and truncate out,
    // which keeps the low bits exact for any width up to UDIV_MAX_W.
    function automatic logic [UDIV_MAX_W-1:0] abs_val(input logic [UDIV_MAX_W-1:0] value,
                                                      input logic                  neg);
        return neg ? (~value + UDIV_MAX_W'(1)) : value;
    endfunction

endpackage

// File: rtl/udiv_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module udiv_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem_c,
    output logic             o_q_bit_c
);

    // One extra bit so the shifted remainder never overflows the compare
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_dvs;
    logic           w_ge;

    assign w_shift   = {i_rem, i_bit};
    assign w_dvs     = {1'b0, i_dvs};
    assign w_ge      = (w_shift >= w_dvs);
    assign o_q_bit_c = w_ge;
    assign o_rem_c   = w_ge ? WIDTH'(w_shift - w_dvs) : WIDTH'(w_shift);

endmodule

// File: rtl/udiv_iter.sv
// Iterative radix-2 restoring divider, signed/unsigned, one quotient bit per cycle.
module udiv_iter
    import udiv_pkg::*;
#(
    parameter  int unsigned WIDTH = UDIV_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_i,
    input  logic             sign_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divider_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o,
    output logic             busy_o,
    output logic             valid_o
);

    udiv_state_e      r_state;
    udiv_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_orig_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero_o;
    logic             r_busy;
    logic             r_valid;

    logic             w_start_ok;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_q_bit;

    assign w_start_ok = start_i && ((r_state == IDLE) || (r_state == DONE));
    assign w_dvd_neg  = sign_i & dividend_i[WIDTH-1];
    assign w_dvs_neg  = sign_i & divider_i[WIDTH-1];
    assign w_dvs_zero = (r_dvs == '0);

    udiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_bit    (r_dvd[r_cnt]),
        .i_dvs    (r_dvs),
        .o_rem_c  (w_step_rem),
        .o_q_bit_c(w_q_bit)
    );

    // State register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start_ok) w_state_nxt = LOAD;
            LOAD: w_state_nxt = w_dvs_zero ? FIX : CALC;
            CALC: if (r_cnt == '0) w_state_nxt = FIX;
            FIX:  if (r_cnt == '0) w_state_nxt = DONE;
            DONE: w_state_nxt = w_start_ok ? LOAD : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (stall_i) w_state_nxt = r_state;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt        <= '0;
            r_dvd        <= '0;
            r_dvs        <= '0;
            r_orig_dvd   <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_sign_q     <= 1'b0;
            r_sign_r     <= 1'b0;
            r_div_zero   <= 1'b0;
            r_quotient   <= '0;
            r_remainder  <= '0;
            r_div_zero_o <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
        end else if (!stall_i) begin
            r_valid <= (w_state_nxt == DONE);
            r_busy  <= (w_state_nxt == LOAD) || (w_state_nxt == CALC) || (w_state_nxt == FIX);
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_orig_dvd <= dividend_i;
                        r_dvd      <= WIDTH'(abs_val(UDIV_MAX_W'(dividend_i), w_dvd_neg));
                        r_dvs      <= WIDTH'(abs_val(UDIV_MAX_W'(divider_i), w_dvs_neg));
                        r_sign_q   <= w_dvd_neg ^ w_dvs_neg;
                        r_sign_r   <= w_dvd_neg;
                    end
                end
                LOAD: begin
                    r_rem <= '0;
                    r_quo <= '0;
                    // Zero divisor parks one extra cycle in FIX for a fixed fast-path latency
                    if (w_dvs_zero) begin
                        r_div_zero <= 1'b1;
                        r_cnt      <= CNT_W'(1);
                    end else begin
                        r_div_zero <= 1'b0;
                        r_cnt      <= CNT_W'(WIDTH - 1);
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                FIX: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_div_zero) begin
                        r_quotient   <= '1;
                        r_remainder  <= r_orig_dvd;
                        r_div_zero_o <= 1'b1;
                    end else begin
                        r_quotient   <= WIDTH'(abs_val(UDIV_MAX_W'(r_quo), r_sign_q));
                        r_remainder  <= WIDTH'(abs_val(UDIV_MAX_W'(r_rem), r_sign_r));
                        r_div_zero_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient_o  = r_quotient;
    assign remainder_o = r_remainder;
    assign div_zero_o  = r_div_zero_o;
    assign busy_o      = r_busy;
    assign valid_o     = r_valid;

endmodule

// File: tb/tb_udiv_iter.sv
// Directed self-checking bench for udiv_iter (WIDTH=64).
module tb_udiv_iter;

    logic        clk_i;
    logic        reset_i;
    logic        stall_i;
    logic        sign_i;
    logic        start_i;
    logic [63:0] dividend_i;
    logic [63:0] divider_i;
    logic [63:0] quotient_o;
    logic [63:0] remainder_o;
    logic        div_zero_o;
    logic        busy_o;
    logic        valid_o;

    int n_checks = 0;
    int n_errors = 0;

    udiv_iter #(
        .WIDTH(64)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .stall_i    (stall_i),
        .sign_i     (sign_i),
        .start_i    (start_i),
        .dividend_i (dividend_i),
        .divider_i  (divider_i),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o),
        .div_zero_o (div_zero_o),
        .busy_o     (busy_o),
        .valid_o    (valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request; returns just after the accepting edge (T)
    task automatic start_op(input logic [63:0] dvd, input logic [63:0] dvs, input logic sgn);
        dividend_i = dvd;
        divider_i  = dvs;
        sign_i     = sgn;
        start_i    = 1'b1;
        @(posedge clk_i); #1;
        start_i    = 1'b0;
    endtask

    // Wait for valid_o, count edges since T, check results; optional mid-CALC stall with spurious starts
    task automatic wait_res(input string tag, input logic [63:0] exp_q, input logic [63:0] exp_r,
                            input logic exp_z, input int exp_lat, input int stall_at, input bit pulse);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk_i); #1;
            n++;
            if (valid_o) begin
                seen = 1'b1;
            end else if (stall_at > 0) begin
                if (n == stall_at) begin
                    stall_i    = 1'b1;
                    start_i    = 1'b1;
                    dividend_i = 64'd5;
                    divider_i  = 64'd0;
                end
                if (n == stall_at + 10) begin
                    stall_i = 1'b0;
                    start_i = 1'b0;
                end
                if (n == stall_at + 12) start_i = 1'b1;
                if (n == stall_at + 13) start_i = 1'b0;
            end
        end
        chk($sformatf("%s latency", tag), 64'(n), 64'(exp_lat));
        chk($sformatf("%s quotient", tag), quotient_o, exp_q);
        chk($sformatf("%s remainder", tag), remainder_o, exp_r);
        chk($sformatf("%s div_zero", tag), 64'(div_zero_o), 64'(exp_z));
        chk($sformatf("%s busy_in_done", tag), 64'(busy_o), 64'd0);
        if (pulse) begin
            @(posedge clk_i); #1;
            chk($sformatf("%s valid_pulse_end", tag), 64'(valid_o), 64'd0);
        end
    endtask

    initial begin
        int vcnt;
        reset_i    = 1'b0;
        stall_i    = 1'b0;
        sign_i     = 1'b0;
        start_i    = 1'b0;
        dividend_i = '0;
        divider_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset quotient", quotient_o, 64'd0);
        chk("reset remainder", remainder_o, 64'd0);
        chk("reset div_zero", 64'(div_zero_o), 64'd0);
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset valid", 64'(valid_o), 64'd0);
        reset_i = 1'b1;
        @(posedge clk_i); #1;

        start_op(64'd100, 64'd7, 1'b0);
        chk("u100_7 busy_after_start", 64'(busy_o), 64'd1);
        wait_res("u100_7", 64'd14, 64'd2, 1'b0, 66, 0, 1'b1);

        start_op(-64'sd100, 64'd7, 1'b1);
        wait_res("s-100_7", 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66, 0, 1'b1);

        start_op(64'd100, -64'sd7, 1'b1);
        wait_res("s100_-7", 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 66, 0, 1'b1);

        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
        wait_res("umax_2", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 66, 0, 1'b1);

        start_op(64'h1234, 64'd0, 1'b0);
        wait_res("u_divzero", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 3, 0, 1'b1);

        start_op(64'h1234, 64'd0, 1'b1);
        wait_res("s_divzero", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 3, 0, 1'b1);

        start_op(64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1);
        wait_res("s_neg_divzero", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 3, 0, 1'b1);

        start_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_res("s_overflow", 64'h8000_0000_0000_0000, 64'd0, 1'b0, 66, 0, 1'b1);

        start_op(64'd1000, 64'd3, 1'b0);
        wait_res("stall_1000_3", 64'd333, 64'd1, 1'b0, 76, 20, 1'b1);

        // Back-to-back: new start taken in DONE while old results are still presented
        start_op(64'd200, 64'd10, 1'b0);
        wait_res("b2b_first", 64'd20, 64'd0, 1'b0, 66, 0, 1'b0);
        start_op(64'd7, 64'd7, 1'b0);
        chk("b2b valid_dropped", 64'(valid_o), 64'd0);
        chk("b2b busy", 64'(busy_o), 64'd1);
        chk("b2b quotient_held", quotient_o, 64'd20);
        wait_res("b2b_second", 64'd1, 64'd0, 1'b0, 66, 0, 1'b1);

        // Abort in the middle of CALC
        start_op(64'd55, 64'd5, 1'b0);
        repeat (31) @(posedge clk_i);
        #1;
        chk("abort busy_before", 64'(busy_o), 64'd1);
        reset_i = 1'b0;
        #1;
        chk("abort quotient", quotient_o, 64'd0);
        chk("abort remainder", remainder_o, 64'd0);
        chk("abort div_zero", 64'(div_zero_o), 64'd0);
        chk("abort busy", 64'(busy_o), 64'd0);
        chk("abort valid", 64'(valid_o), 64'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk_i); #1;
            if (valid_o) vcnt++;
        end
        chk("abort no_valid", 64'(vcnt), 64'd0);

        start_op(64'd81, 64'd9, 1'b0);
        wait_res("u81_9", 64'd9, 64'd0, 1'b0, 66, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/udiv_iter.md
Name: udiv_iter

Overview:
- Iterative radix-2 restoring integer divider.
- It is the responder side of the start/valid divide handshake used by the FPU division datapath and the integer M-extension path.
- Accepts one operation at a time, computes one quotient bit per cycle, and returns quotient, remainder and a divide-by-zero flag with a single-cycle valid pulse.
- Supports unsigned and two's-complement signed operands, and a global pipeline stall.

Parameters:
WIDTH, 64, operand/result width in bits (must be >= 2).
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
clk_i  input  1  clock, rising edge.
reset_i  input  1  asynchronous, active-low reset.
stall_i  input  1  freeze: when high, no register changes state.
sign_i  input  1  1 = signed operands, 0 = unsigned; sampled with start_i.
start_i  input  1  request; accepted in IDLE or DONE when stall_i=0.
dividend_i  input  WIDTH  dividend; sampled on accepted start.
divider_i  input  WIDTH  divisor; sampled on accepted start.
quotient_o  output  WIDTH  quotient; held until next accepted start.
remainder_o  output  WIDTH  remainder; held until next accepted start.
div_zero_o  output  1  divisor was zero; qualified by valid_o, held with results.
busy_o  output  1  high in LOAD, CALC and FIX.
valid_o  output  1  one-cycle (non-stalled) pulse: results are valid.

Behaviour:
- Reset (async, reset_i=0): state=IDLE; quotient_o, remainder_o, div_zero_o, busy_o, valid_o all 0; counter and internal registers 0.
- States: IDLE, LOAD, CALC, FIX, DONE. Every transition and every register update is gated by !stall_i.
- IDLE/DONE with start_i=1:
  - latch operands and sign_i; record sign_q = sign_i & (dividend[MSB] ^ divider[MSB]) and sign_r = sign_i & dividend[MSB].
  - store absolute values when sign_i=1, else raw values.
  - go to LOAD.
- DONE without start_i: go to IDLE.
- start_i in LOAD/CALC/FIX is ignored (no queueing).
- LOAD:
  - divisor==0: set div_zero flag and go to FIX (fast path).
  - otherwise: clear partial remainder, set counter=WIDTH-1, go to CALC.
- CALC (WIDTH cycles), per step:
  - rem' = {rem[WIDTH-1:0], dvd[counter]};
  - if rem' >= |divisor|: rem' -= |divisor| and quotient bit = 1, else bit = 0.
  - The remainder datapath is WIDTH+1 bits wide to avoid compare overflow.
  - Counter decrements; at counter==0 go to FIX.
- FIX:
  - quotient_o = sign_q ? -q : q; remainder_o = sign_r ? -r : r.
  - Divide by zero: quotient_o = all ones, remainder_o = original dividend_i, div_zero_o=1. No sign fix is applied.
  - Go to DONE.
- DONE: valid_o=1 for this cycle only.
- valid_o is registered and asserted while the state is DONE. If stall_i is high in DONE, valid_o stays high until the first non-stalled cycle.
- Latency, start accepted at edge T, no stall:
  - normal operation: valid_o high in the cycle after edge T+WIDTH+2;
  - divide by zero: valid_o high in the cycle after edge T+3.
- Each stalled cycle adds exactly one cycle of latency.
- Signed overflow (most-negative / -1): the algorithm yields quotient = most-negative and remainder = 0 with no special casing. This is required behaviour.
- Back-to-back: start_i in DONE is accepted. valid_o pulses for the old result while the new operands load; outputs update only at the next FIX.
- Reset mid-operation returns to IDLE immediately. No valid_o is produced for the aborted operation.

Decomposition:
- Package udiv_pkg:
  - udiv_state_e enum (IDLE, LOAD, CALC, FIX, DONE);
  - localparam default WIDTH;
  - helper function abs_val(value, sign_en).
- One sub-module, udiv_step: a combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Instantiated once inside udiv_iter.

Test Plan:
1. Unsigned 100/7, sign_i=0 -> quotient_o=14, remainder_o=2, div_zero_o=0; valid_o high exactly one cycle, in cycle T+WIDTH+3 (67 for WIDTH=64).
2. Signed -100/7 -> quotient_o=0xFFFF_FFFF_FFFF_FFF2, remainder_o=0xFFFF_FFFF_FFFF_FFFE. Signed 100/-7 -> quotient_o=-14, remainder_o=+2.
3. 0x1234/0, either sign mode -> quotient_o=0xFFFF_FFFF_FFFF_FFFF, remainder_o=0x1234, div_zero_o=1; valid_o at T+4.
4. Signed 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> quotient_o=0x8000_0000_0000_0000, remainder_o=0, div_zero_o=0.
5. 1000/3 with stall_i high for 10 cycles mid-CALC plus a spurious start_i while busy -> quotient_o=333, remainder_o=1; valid_o delayed exactly 10 cycles; spurious start has no effect.
6. reset_i pulled low on CALC cycle 30 -> all outputs 0, busy_o=0, no valid_o. A following 81/9 -> quotient_o=9, remainder_o=0 at the normal latency.
